// File: rtl/pong_pkg.sv
// Shared definitions for the pong game: FSM state encoding, winner codes and
// screen geometry used by the mover, the renderer and the match sequencer.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_POINT = 3'd4,
    ST_OVER  = 3'd5
  } game_state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  localparam logic [9:0] vga_xdis = 10'd800;
  localparam logic [9:0] vga_ydis = 10'd600;
  localparam logic [9:0] side     = 10'd40;
  localparam logic [9:0] block    = 10'd40;
  localparam logic [9:0] stick    = 10'd100;

endpackage

// File: rtl/pong_tick_timer.sv
// 8-bit motion-tick counter with synchronous clear and a terminal-count flag
// that is high while the count sits at limit-1.
module pong_tick_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  input  logic [7:0] limit,
  output logic       done
);

  logic [7:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= 8'd0;
    end else if (clr) begin
      count_reg <= 8'd0;
    end else if (inc) begin
      count_reg <= count_reg + 8'd1;
    end
  end

  assign done = (count_reg == (limit - 8'd1));

endmodule

// File: rtl/pong_game_ctrl.sv
// Match sequencer: gates the motion tick, detects misses from ball_y, keeps
// both scores and steps through serve / play / pause / point / game-over.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter logic [9:0] TOP_MISS    = 10'd10,
  parameter logic [9:0] BOT_MISS    = 10'd590,
  parameter logic [7:0] SERVE_TICKS = 8'd100,
  parameter logic [7:0] POINT_TICKS = 8'd50,
  parameter logic [3:0] WIN_SCORE   = 4'd7,
  parameter logic [9:0] SERVE_X     = 10'd380,
  parameter logic [9:0] SERVE_Y     = 10'd280
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start_key,
  input  logic       pause_key,
  input  logic [9:0] ball_y,
  output logic       move_en,
  output logic       ball_load,
  output logic [9:0] load_x,
  output logic [9:0] load_y,
  output logic       serve_dir,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] winner,
  output logic [2:0] game_state
);

  game_state_t state_reg, state_next;
  logic [3:0]  score1_reg, score1_next;
  logic [3:0]  score2_reg, score2_next;
  logic [1:0]  winner_reg, winner_next;
  logic        serve_dir_reg, serve_dir_next;
  logic        ball_load_reg, ball_load_next;

  logic       timer_clr;
  logic       timer_inc;
  logic       timer_done;
  logic [7:0] timer_limit;

  // One counter serves both timed phases; the limit follows the state.
  assign timer_limit = (state_reg == ST_SERVE) ? SERVE_TICKS : POINT_TICKS;

  pong_tick_timer u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (timer_clr),
    .inc   (timer_inc),
    .limit (timer_limit),
    .done  (timer_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      score1_reg    <= 4'd0;
      score2_reg    <= 4'd0;
      winner_reg    <= WIN_NONE;
      serve_dir_reg <= 1'b1;
      ball_load_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      score1_reg    <= score1_next;
      score2_reg    <= score2_next;
      winner_reg    <= winner_next;
      serve_dir_reg <= serve_dir_next;
      ball_load_reg <= ball_load_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    score1_next    = score1_reg;
    score2_next    = score2_reg;
    winner_next    = winner_reg;
    serve_dir_next = serve_dir_reg;
    ball_load_next = 1'b0;
    timer_clr      = 1'b0;
    timer_inc      = 1'b0;

    case (state_reg)
      ST_IDLE, ST_OVER: begin
        if (start_key) begin
          score1_next    = 4'd0;
          score2_next    = 4'd0;
          winner_next    = WIN_NONE;
          serve_dir_next = 1'b1;
          ball_load_next = 1'b1;
          state_next     = ST_SERVE;
        end
      end
      ST_SERVE: begin
        timer_inc = tick;
        if (tick && timer_done) begin
          timer_clr  = 1'b1;
          state_next = ST_PLAY;
        end
      end
      ST_PLAY: begin
        // Misses outrank a simultaneous pause request.
        if (ball_y >= BOT_MISS) begin
          score2_next    = score2_reg + 4'd1;
          serve_dir_next = 1'b1;
          state_next     = ST_POINT;
        end else if (ball_y <= TOP_MISS) begin
          score1_next    = score1_reg + 4'd1;
          serve_dir_next = 1'b0;
          state_next     = ST_POINT;
        end else if (pause_key) begin
          state_next = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (pause_key) begin
          state_next = ST_PLAY;
        end
      end
      ST_POINT: begin
        timer_inc = tick;
        if (tick && timer_done) begin
          timer_clr = 1'b1;
          if (score1_reg == WIN_SCORE) begin
            winner_next = WIN_P1;
            state_next  = ST_OVER;
          end else if (score2_reg == WIN_SCORE) begin
            winner_next = WIN_P2;
            state_next  = ST_OVER;
          end else begin
            ball_load_next = 1'b1;
            state_next     = ST_SERVE;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign move_en    = tick & (state_reg == ST_PLAY);
  assign ball_load  = ball_load_reg;
  assign load_x     = SERVE_X;
  assign load_y     = SERVE_Y;
  assign serve_dir  = serve_dir_reg;
  assign score1     = score1_reg;
  assign score2     = score2_reg;
  assign winner     = winner_reg;
  assign game_state = state_reg;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with short serve/point phases and a
// two-point match so every phase transition is reached quickly.
module tb_pong_game_ctrl;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       start_key;
  logic       pause_key;
  logic [9:0] ball_y;
  logic       move_en;
  logic       ball_load;
  logic [9:0] load_x;
  logic [9:0] load_y;
  logic       serve_dir;
  logic [3:0] score1;
  logic [3:0] score2;
  logic [1:0] winner;
  logic [2:0] game_state;

  int total = 0;
  int bad   = 0;

  pong_game_ctrl #(
    .SERVE_TICKS (8'd3),
    .POINT_TICKS (8'd2),
    .WIN_SCORE   (4'd2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .start_key  (start_key),
    .pause_key  (pause_key),
    .ball_y     (ball_y),
    .move_en    (move_en),
    .ball_load  (ball_load),
    .load_x     (load_x),
    .load_y     (load_y),
    .serve_dir  (serve_dir),
    .score1     (score1),
    .score2     (score2),
    .winner     (winner),
    .game_state (game_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick = 1'b0; start_key = 1'b0; pause_key = 1'b0; ball_y = 10'd300;
    step(); step();
    total++; if (game_state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", game_state); end
    total++; if (move_en !== 1'b0) begin bad++; $display("FAIL reset_move_en got=%b exp=0", move_en); end
    total++; if (ball_load !== 1'b0) begin bad++; $display("FAIL reset_ball_load got=%b exp=0", ball_load); end
    total++; if (serve_dir !== 1'b1) begin bad++; $display("FAIL reset_serve_dir got=%b exp=1", serve_dir); end
    total++; if (score1 !== 4'd0 || score2 !== 4'd0) begin bad++; $display("FAIL reset_scores got=%0d/%0d exp=0/0", score1, score2); end
    total++; if (winner !== 2'b00) begin bad++; $display("FAIL reset_winner got=%b exp=00", winner); end
    total++; if (load_x !== 10'd380 || load_y !== 10'd280) begin bad++; $display("FAIL load_xy got=%0d,%0d exp=380,280", load_x, load_y); end
    @(negedge clk); rst_n = 1'b1;
    step();
    $display("reset: state=%0d scores=%0d/%0d", game_state, score1, score2);
  endtask

  // Three ticks in SERVE, each with move_en held low, then PLAY.
  task automatic serve_to_play(input string tag);
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1; #1;
      total++; if (move_en !== 1'b0) begin bad++; $display("FAIL %s_serve_move_en tick=%0d got=%b exp=0", tag, i, move_en); end
      step(); tick = 1'b0;
      total++; if (game_state !== ((i == 2) ? 3'd2 : 3'd1)) begin
        bad++; $display("FAIL %s_serve_state tick=%0d got=%0d exp=%0d", tag, i, game_state, (i == 2) ? 2 : 1);
      end
      step();
    end
    $display("%s: serve done state=%0d", tag, game_state);
  endtask

  task automatic test_start();
    start_key = 1'b1; step(); start_key = 1'b0;
    total++; if (ball_load !== 1'b1) begin bad++; $display("FAIL start_ball_load got=%b exp=1", ball_load); end
    total++; if (game_state !== 3'd1) begin bad++; $display("FAIL start_state got=%0d exp=1", game_state); end
    step();
    total++; if (ball_load !== 1'b0) begin bad++; $display("FAIL start_ball_load_width got=%b exp=0", ball_load); end
    serve_to_play("start");
    tick = 1'b1; #1;
    total++; if (move_en !== 1'b1) begin bad++; $display("FAIL play_move_en got=%b exp=1", move_en); end
    step(); tick = 1'b0; #1;
    total++; if (move_en !== 1'b0) begin bad++; $display("FAIL play_move_en_idle got=%b exp=0", move_en); end
    $display("start: state=%0d", game_state);
  endtask

  task automatic test_bottom_miss();
    ball_y = 10'd595; step();
    total++; if (score2 !== 4'd1) begin bad++; $display("FAIL bot_score2 got=%0d exp=1", score2); end
    total++; if (serve_dir !== 1'b1) begin bad++; $display("FAIL bot_serve_dir got=%b exp=1", serve_dir); end
    total++; if (game_state !== 3'd4) begin bad++; $display("FAIL bot_state got=%0d exp=4", game_state); end
    tick = 1'b1; #1;
    total++; if (move_en !== 1'b0) begin bad++; $display("FAIL point_move_en got=%b exp=0", move_en); end
    step(); tick = 1'b0; step();
    total++; if (game_state !== 3'd4 || score2 !== 4'd1) begin bad++; $display("FAIL point_hold got=%0d/%0d exp=4/1", game_state, score2); end
    tick = 1'b1; step(); tick = 1'b0;
    total++; if (game_state !== 3'd1 || ball_load !== 1'b1) begin bad++; $display("FAIL point_expiry got=%0d/%b exp=1/1", game_state, ball_load); end
    total++; if (score2 !== 4'd1 || score1 !== 4'd0) begin bad++; $display("FAIL point_no_recount got=%0d/%0d exp=0/1", score1, score2); end
    ball_y = 10'd300; step();
    total++; if (ball_load !== 1'b0) begin bad++; $display("FAIL point_load_width got=%b exp=0", ball_load); end
    serve_to_play("bot");
    $display("bottom_miss: scores=%0d/%0d state=%0d", score1, score2, game_state);
  endtask

  task automatic test_pause();
    pause_key = 1'b1; step(); pause_key = 1'b0;
    total++; if (game_state !== 3'd3) begin bad++; $display("FAIL pause_enter got=%0d exp=3", game_state); end
    for (int i = 0; i < 5; i++) begin
      tick = 1'b1; start_key = (i == 2); #1;
      total++; if (move_en !== 1'b0) begin bad++; $display("FAIL pause_move_en tick=%0d got=%b exp=0", i, move_en); end
      step(); tick = 1'b0; start_key = 1'b0;
    end
    total++; if (game_state !== 3'd3) begin bad++; $display("FAIL pause_hold got=%0d exp=3", game_state); end
    pause_key = 1'b1; step(); pause_key = 1'b0;
    total++; if (game_state !== 3'd2) begin bad++; $display("FAIL pause_exit got=%0d exp=2", game_state); end
    tick = 1'b1; #1;
    total++; if (move_en !== 1'b1) begin bad++; $display("FAIL resume_move_en got=%b exp=1", move_en); end
    step(); tick = 1'b0;
    $display("pause: state=%0d", game_state);
  endtask

  task automatic test_miss_vs_pause();
    ball_y = 10'd5; pause_key = 1'b1; step(); pause_key = 1'b0; ball_y = 10'd300;
    total++; if (score1 !== 4'd1) begin bad++; $display("FAIL mvp_score1 got=%0d exp=1", score1); end
    total++; if (game_state !== 3'd4) begin bad++; $display("FAIL mvp_state got=%0d exp=4", game_state); end
    total++; if (serve_dir !== 1'b0) begin bad++; $display("FAIL mvp_serve_dir got=%b exp=0", serve_dir); end
    tick = 1'b1; step(); step(); tick = 1'b0;
    total++; if (game_state !== 3'd1 || ball_load !== 1'b1) begin bad++; $display("FAIL mvp_reserve got=%0d/%b exp=1/1", game_state, ball_load); end
    step();
    serve_to_play("mvp");
    $display("miss_vs_pause: scores=%0d/%0d", score1, score2);
  endtask

  task automatic test_win();
    ball_y = 10'd10; step(); ball_y = 10'd300;
    total++; if (score1 !== 4'd2 || game_state !== 3'd4) begin bad++; $display("FAIL win_point got=%0d/%0d exp=2/4", score1, game_state); end
    tick = 1'b1; step(); step(); tick = 1'b0;
    total++; if (game_state !== 3'd5) begin bad++; $display("FAIL win_state got=%0d exp=5", game_state); end
    total++; if (winner !== 2'b01) begin bad++; $display("FAIL win_winner got=%b exp=01", winner); end
    total++; if (ball_load !== 1'b0) begin bad++; $display("FAIL win_no_load got=%b exp=0", ball_load); end
    ball_y = 10'd0; step(); step(); ball_y = 10'd300;
    total++; if (score1 !== 4'd2 || score2 !== 4'd1 || winner !== 2'b01) begin
      bad++; $display("FAIL over_hold got=%0d/%0d/%b exp=2/1/01", score1, score2, winner);
    end
    start_key = 1'b1; step(); start_key = 1'b0;
    total++; if (score1 !== 4'd0 || score2 !== 4'd0 || winner !== 2'b00) begin
      bad++; $display("FAIL restart_clear got=%0d/%0d/%b exp=0/0/00", score1, score2, winner);
    end
    total++; if (ball_load !== 1'b1 || game_state !== 3'd1 || serve_dir !== 1'b1) begin
      bad++; $display("FAIL restart_serve got=%b/%0d/%b exp=1/1/1", ball_load, game_state, serve_dir);
    end
    step();
    $display("win: winner cleared state=%0d", game_state);
  endtask

  task automatic test_reset_mid();
    serve_to_play("mid");
    ball_y = 10'd600; step(); ball_y = 10'd300;
    total++; if (game_state !== 3'd4 || score2 !== 4'd1) begin bad++; $display("FAIL mid_setup got=%0d/%0d exp=4/1", game_state, score2); end
    tick = 1'b1; #2; rst_n = 1'b0; #1;
    total++; if (game_state !== 3'd0 || score2 !== 4'd0 || score1 !== 4'd0) begin
      bad++; $display("FAIL async_reset got=%0d/%0d/%0d exp=0/0/0", game_state, score1, score2);
    end
    total++; if (serve_dir !== 1'b1 || winner !== 2'b00 || ball_load !== 1'b0 || move_en !== 1'b0) begin
      bad++; $display("FAIL async_reset_outs got=%b/%b/%b/%b exp=1/00/0/0", serve_dir, winner, ball_load, move_en);
    end
    @(negedge clk); rst_n = 1'b1; tick = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (ball_load !== 1'b0 || game_state !== 3'd0) begin
        bad++; $display("FAIL post_reset cyc=%0d got=%b/%0d exp=0/0", i, ball_load, game_state);
      end
    end
    $display("reset_mid: state=%0d", game_state);
  endtask

  initial begin
    test_reset();
    test_start();
    test_bottom_miss();
    test_pause();
    test_miss_vs_pause();
    test_win();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
